// File: rtl/user_proj_mc_pkg.sv
// Shared definitions for the multi-channel Wishbone counter: register map,
// CTRL/STATUS bit layout and the per-channel register structs.
package user_proj_mc_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_DOWN    = 1;
  localparam int CTRL_ONESHOT = 2;
  localparam int CTRL_IRQ_EN  = 3;

  localparam int STAT_DONE    = 0;
  localparam int STAT_RUNNING = 1;

  // Field order makes bit 0 = en, matching the CTRL register layout.
  typedef struct packed {
    logic irq_en;
    logic oneshot;
    logic down;
    logic en;
  } ch_ctrl_t;

  typedef struct packed {
    logic running;
    logic done;
  } ch_status_t;

  function automatic logic [31:0] sel_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  sel);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/user_proj_mc_channel.sv
// One counter channel: CTRL/LOAD/COUNT registers, sticky done flag and the
// toggle output, with bus writes applied on the request cycle.
module user_proj_mc_channel
  import user_proj_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_ctrl,
  input  logic             wr_load,
  input  logic             wr_count,
  input  logic             wr_status,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wsel,
  input  logic             pause,
  output ch_ctrl_t         ctrl,
  output logic [CNT_W-1:0] load,
  output logic [CNT_W-1:0] count,
  output logic             done,
  output logic             toggle
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [31:0]      load_ext, count_ext, load_merged, count_merged;
  logic             active, term;
  logic [CNT_W-1:0] count_step, count_d, load_d;
  ch_ctrl_t         ctrl_d;
  logic             done_d;
  logic             unused_hi;

  always_comb begin
    load_ext  = '0;
    count_ext = '0;
    load_ext[CNT_W-1:0]  = load;
    count_ext[CNT_W-1:0] = count;
  end

  assign load_merged  = sel_merge(load_ext, wdata, wsel);
  assign count_merged = sel_merge(count_ext, wdata, wsel);
  assign unused_hi    = ^{load_merged, count_merged};

  // A paused channel neither moves nor detects its terminal value.
  assign active = ctrl.en & ~pause;
  assign term   = active & (ctrl.down ? (count == '0) : (count == load));

  always_comb begin
    count_step = count;
    if (ctrl.down) count_step = term ? load : count - ONE;
    else           count_step = term ? '0   : count + ONE;

    count_d = count;
    if (wr_count)    count_d = count_merged[CNT_W-1:0];
    else if (active) count_d = count_step;

    load_d = wr_load ? load_merged[CNT_W-1:0] : load;

    // A bus write to CTRL overrides the oneshot self-disable.
    ctrl_d = ctrl;
    if (term && ctrl.oneshot)  ctrl_d.en = 1'b0;
    if (wr_ctrl && wsel[0])    ctrl_d = ch_ctrl_t'(wdata[3:0]);

    // Hardware set beats a same-cycle write-1-to-clear.
    done_d = done;
    if (wr_status && wsel[0] && wdata[STAT_DONE]) done_d = 1'b0;
    if (term)                                     done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl   <= '0;
      load   <= '0;
      count  <= '0;
      done   <= 1'b0;
      toggle <= 1'b0;
    end else begin
      ctrl   <= ctrl_d;
      load   <= load_d;
      count  <= count_d;
      done   <= done_d;
      toggle <= toggle ^ term;
    end
  end

endmodule

// File: rtl/user_proj_multicounter.sv
// Multi-channel counter behind a Wishbone slave; top level holds the address
// decode, read mux, irq combine and logic-analyser/IO mapping.
module user_proj_multicounter
  import user_proj_mc_pkg::*;
#(
  parameter int          NUM_CH   = 4,
  parameter int          CNT_W    = 32,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic [127:0]      la_data_in,
  output logic [127:0]      la_data_out,
  input  logic [127:0]      la_oenb,
  output logic [NUM_CH-1:0] io_out,
  output logic [NUM_CH-1:0] io_oeb,
  output logic [2:0]        irq
);

  logic             hit, req;
  logic [3:0]       ch_sel;
  logic [1:0]       reg_sel;
  ch_ctrl_t         ctrl_q  [NUM_CH];
  logic [CNT_W-1:0] load_q  [NUM_CH];
  logic [CNT_W-1:0] count_q [NUM_CH];
  logic [NUM_CH-1:0] done_q, io_q, irq_en_v;
  logic [31:0]      rd_data;
  logic             irq_q;
  logic             unused_ok;

  // Handshake: a request is cyc&stb&hit while no ack is outstanding; the
  // write lands and read data is captured on that edge, ack follows for one
  // cycle, so back-to-back strobes are served every other cycle.
  assign hit     = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign req     = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
  assign ch_sel  = wbs_adr_i[7:4];
  assign reg_sel = wbs_adr_i[3:2];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_ch;
    assign wr_ch = req & wbs_we_i & (ch_sel == 4'(i));

    user_proj_mc_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .wr_ctrl   (wr_ch && reg_sel == REG_CTRL),
      .wr_load   (wr_ch && reg_sel == REG_LOAD),
      .wr_count  (wr_ch && reg_sel == REG_COUNT),
      .wr_status (wr_ch && reg_sel == REG_STATUS),
      .wdata     (wbs_dat_i),
      .wsel      (wbs_sel_i),
      .pause     (~la_oenb[i] & la_data_in[i]),
      .ctrl      (ctrl_q[i]),
      .load      (load_q[i]),
      .count     (count_q[i]),
      .done      (done_q[i]),
      .toggle    (io_q[i])
    );

    assign irq_en_v[i] = ctrl_q[i].irq_en;
  end

  // Channel indices without a matching instance fall through and read 0.
  always_comb begin
    ch_status_t st;
    rd_data = '0;
    st      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_sel == 4'(i)) begin
        case (reg_sel)
          REG_CTRL:  rd_data[3:0]       = ctrl_q[i];
          REG_LOAD:  rd_data[CNT_W-1:0] = load_q[i];
          REG_COUNT: rd_data[CNT_W-1:0] = count_q[i];
          default: begin
            st.done    = done_q[i];
            st.running = ctrl_q[i].en;
            rd_data[1:0] = st;
          end
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      irq_q     <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= req ? rd_data : '0;
      irq_q     <= |(done_q & irq_en_v);
    end
  end

  always_comb begin
    la_data_out = '0;
    la_data_out[NUM_CH-1:0]  = done_q;
    la_data_out[64 +: CNT_W] = count_q[0];
  end

  assign irq       = {2'b00, irq_q};
  assign io_out    = io_q;
  assign io_oeb    = '0;
  assign unused_ok = ^{wbs_adr_i[1:0], la_data_in, la_oenb};

endmodule

// File: tb/tb_user_proj_multicounter.sv
// Bench for user_proj_multicounter: directed register scenarios plus random
// bus/pause traffic, all checked against a cycle-level behavioural model.
module tb_user_proj_multicounter;

  localparam int          NUM_CH = 4;
  localparam int          CNT_W  = 32;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] MASK   = (CNT_W >= 32) ? 32'hFFFF_FFFF
                                                 : 32'((64'd1 << CNT_W) - 64'd1);

  // clock / reset and DUT signals
  logic              wb_clk_i, wb_rst_i;
  logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i, wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic [127:0]      la_data_in, la_oenb, la_data_out;
  logic [NUM_CH-1:0] io_out, io_oeb;
  logic [2:0]        irq;

  user_proj_multicounter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .BASE_ADR(BASE)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .la_data_in(la_data_in), .la_data_out(la_data_out), .la_oenb(la_oenb),
    .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // scoreboard state
  int          n_vec  = 0;
  int          n_fail = 0;
  logic        chk_on = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // behavioural model state
  logic [3:0]  m_ctrl  [NUM_CH];
  logic [31:0] m_load  [NUM_CH];
  logic [31:0] m_count [NUM_CH];
  logic        m_done  [NUM_CH];
  logic        m_io    [NUM_CH];
  logic        m_ack, m_irq;
  logic [31:0] m_dat;

  function automatic logic [31:0] byte_write(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r & MASK;
  endfunction

  function automatic logic [31:0] model_read(input int c, input logic [1:0] rg);
    logic [31:0] r;
    r = '0;
    if (c < NUM_CH) begin
      case (rg)
        2'd0:    r = {28'd0, m_ctrl[c]};
        2'd1:    r = m_load[c];
        2'd2:    r = m_count[c];
        default: r = {30'd0, m_ctrl[c][0], m_done[c]};
      endcase
    end
    return r;
  endfunction

  function automatic logic [127:0] exp_la();
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) r[c] = m_done[c];
    r[64 +: 32] = m_count[0];
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] exp_io();
    logic [NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = m_io[c];
    return r;
  endfunction

  always @(posedge wb_clk_i) begin
    logic        req, act, term, irq_n, c_done;
    int          ch;
    logic [1:0]  rg;
    logic [31:0] rd, c_load, c_count;
    logic [3:0]  c_ctrl;
    if (wb_rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_ctrl[c] = '0; m_load[c] = '0; m_count[c] = '0; m_done[c] = 1'b0; m_io[c] = 1'b0;
      end
      m_ack = 1'b0; m_dat = '0; m_irq = 1'b0;
    end else begin
      req   = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:8] == BASE[31:8]) && !m_ack;
      ch    = int'(wbs_adr_i[7:4]);
      rg    = wbs_adr_i[3:2];
      rd    = model_read(ch, rg);
      irq_n = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        irq_n   = irq_n | (m_done[c] & m_ctrl[c][3]);
        c_ctrl  = m_ctrl[c];
        c_load  = m_load[c];
        c_count = m_count[c];
        c_done  = m_done[c];
        act  = c_ctrl[0] && !(!la_oenb[c] && la_data_in[c]);
        term = act && (c_ctrl[1] ? (c_count == 0) : (c_count == c_load));
        if (act) begin
          if (c_ctrl[1]) c_count = term ? c_load : ((c_count - 1) & MASK);
          else           c_count = term ? 32'd0  : ((c_count + 1) & MASK);
        end
        if (term && c_ctrl[2]) c_ctrl[0] = 1'b0;
        if (req && wbs_we_i && ch == c) begin
          case (rg)
            2'd0: if (wbs_sel_i[0]) c_ctrl = wbs_dat_i[3:0];
            2'd1: c_load  = byte_write(m_load[c], wbs_dat_i, wbs_sel_i);
            2'd2: c_count = byte_write(m_count[c], wbs_dat_i, wbs_sel_i);
            default: if (wbs_sel_i[0] && wbs_dat_i[0]) c_done = 1'b0;
          endcase
        end
        if (term) c_done = 1'b1;
        m_io[c]    = m_io[c] ^ term;
        m_ctrl[c]  = c_ctrl;
        m_load[c]  = c_load;
        m_count[c] = c_count;
        m_done[c]  = c_done;
      end
      m_ack = req;
      m_dat = req ? rd : 32'd0;
      m_irq = irq_n;
    end
  end

  // per-cycle comparison of every output against the model
  always @(negedge wb_clk_i) begin
    if (chk_on) begin
      check("ack",     128'(wbs_ack_o),   128'(m_ack));
      check("dat_o",   128'(wbs_dat_o),   128'(m_dat));
      check("io_out",  128'(io_out),      128'(exp_io()));
      check("irq",     128'(irq),         128'({2'b00, m_irq}));
      check("la_out",  la_data_out,       exp_la());
      check("io_oeb",  128'(io_oeb),      128'(0));
    end
  end

  // driver tasks (called at a falling edge)
  task automatic bus_cycle(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic [31:0] rdata, output logic acked);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    acked = 1'b0; rdata = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o) begin
        acked = 1'b1;
        rdata = wbs_dat_o;
        break;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] rd;
    logic        ok;
    bus_cycle(1'b1, adr, dat, sel, rd, ok);
    check("wr_ack", 128'(ok), 128'(1));
  endtask

  task automatic wb_read_expect(input string tag, input logic [31:0] adr, input logic [31:0] exp);
    logic [31:0] rd, e;
    logic        ok;
    exp_q.push_back(exp);
    bus_cycle(1'b0, adr, 32'd0, 4'hF, rd, ok);
    check({tag, "_ack"}, 128'(ok), 128'(1));
    e = exp_q.pop_front();
    check(tag, 128'(rd), 128'(e));
  endtask

  function automatic logic [31:0] reg_adr(input int ch, input int rg);
    return BASE | (32'(ch) << 4) | (32'(rg) << 2);
  endfunction

  initial begin
    int          up_seq[5];
    logic [31:0] frozen, rd;
    logic        ok;
    up_seq = '{1, 2, 3, 0, 1};
    wb_rst_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
    la_data_in = '0; la_oenb = '1;
    repeat (3) @(negedge wb_clk_i);
    chk_on = 1'b1;
    wb_rst_i = 1'b0;

    for (int c = 0; c < NUM_CH; c++)
      for (int r = 0; r < 4; r++) wb_read_expect("rst_reg", reg_adr(c, r), 32'd0);

    // up wrap on channel 0
    wb_write(reg_adr(0, 1), 32'd3, 4'hF);
    wb_write(reg_adr(0, 0), 32'h1, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge wb_clk_i);
      check("up_wrap_cnt", 128'(la_data_out[64 +: 32]), 128'(up_seq[i]));
    end
    check("up_done", 128'(la_data_out[0]), 128'(1));
    check("up_io_toggle", 128'(io_out[0]), 128'(1));
    repeat (3) @(negedge wb_clk_i);
    check("up_io_period", 128'(io_out[0]), 128'(0));

    // down oneshot on channel 1
    wb_write(reg_adr(1, 1), 32'd2, 4'hF);
    wb_write(reg_adr(1, 2), 32'd2, 4'hF);
    wb_write(reg_adr(1, 0), 32'h7, 4'hF);
    repeat (6) @(negedge wb_clk_i);
    wb_read_expect("os_count", reg_adr(1, 2), 32'd2);
    wb_read_expect("os_ctrl",  reg_adr(1, 0), 32'h6);
    wb_read_expect("os_status", reg_adr(1, 3), 32'h1);

    // irq and write-1-to-clear on channel 2
    wb_write(reg_adr(2, 1), 32'd1, 4'hF);
    wb_write(reg_adr(2, 0), 32'h9, 4'hF);
    repeat (4) @(negedge wb_clk_i);
    check("irq_set", 128'(irq[0]), 128'(1));
    wb_write(reg_adr(2, 0), 32'h8, 4'hF);
    wb_write(reg_adr(2, 3), 32'h1, 4'hF);
    check("irq_hold", 128'(irq[0]), 128'(1));
    @(negedge wb_clk_i);
    check("irq_clear", 128'(irq[0]), 128'(0));
    wb_read_expect("w1c_status", reg_adr(2, 3), 32'h0);

    // bus decode corners
    wb_read_expect("ch5_read", reg_adr(5, 2), 32'd0);
    bus_cycle(1'b0, BASE + 32'h100, 32'd0, 4'hF, rd, ok);
    check("nohit_ack", 128'(ok), 128'(0));
    wb_write(reg_adr(3, 1), 32'hFFFF_FFFF, 4'b0001);
    wb_read_expect("sel_load", reg_adr(3, 1), 32'h0000_00FF);

    // COUNT write priority, then pause on channel 0
    wb_write(reg_adr(3, 1), 32'h1000, 4'hF);
    wb_write(reg_adr(3, 0), 32'h1, 4'hF);
    wb_write(reg_adr(3, 2), 32'h10, 4'hF);
    wb_read_expect("cnt_prio", reg_adr(3, 2), 32'h11);
    la_oenb[0] = 1'b0; la_data_in[0] = 1'b1;
    frozen = m_count[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge wb_clk_i);
      check("pause_cnt", 128'(la_data_out[64 +: 32]), 128'(frozen));
    end
    la_oenb[0] = 1'b1; la_data_in[0] = 1'b0;

    // reset during a pending access
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = reg_adr(3, 2);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check("rst_no_ack", 128'(wbs_ack_o), 128'(0));
    wb_rst_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge wb_clk_i);
    check("rst_no_ack2", 128'(wbs_ack_o), 128'(0));
    wb_read_expect("rst_count", reg_adr(3, 2), 32'd0);
    wb_read_expect("rst_ctrl",  reg_adr(0, 0), 32'd0);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      int          ch, rg;
      logic [31:0] adr, dat;
      logic [3:0]  sel;
      logic        we;
      if ($urandom_range(0, 7) == 0) begin
        la_oenb[NUM_CH-1:0]    = NUM_CH'($urandom());
        la_data_in[NUM_CH-1:0] = NUM_CH'($urandom());
      end
      ch  = $urandom_range(0, 5);
      rg  = $urandom_range(0, 3);
      adr = reg_adr(ch, rg) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) begin
        adr = $urandom();
        if (adr[31:8] == BASE[31:8]) adr[31] = ~adr[31];
      end
      case (rg)
        0:       dat = 32'($urandom_range(0, 15));
        3:       dat = 32'($urandom_range(0, 1));
        default: dat = 32'($urandom_range(0, 12));
      endcase
      if ($urandom_range(0, 9) == 0) dat = $urandom();
      sel = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
      we  = 1'($urandom_range(0, 1));
      bus_cycle(we, adr, dat, sel, rd, ok);
      repeat ($urandom_range(0, 3)) @(negedge wb_clk_i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/user_proj_multicounter.md
USER_PROJ_MULTICOUNTER -- requirements
Module: user_proj_multicounter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent counter channels, legal range 1..16.
REQ-002 SHALL have parameter CNT_W, default 32: counter width, legal range 8..32.
REQ-003 SHALL have parameter BASE_ADR, default 32'h3000_0000: Wishbone base address; bits [7:0] SHALL be ignored.
REQ-004 SHALL use one clock and a synchronous, active-high reset:
  wb_clk_i  in  1  sole clock; all logic on rising edge.
  wb_rst_i  in  1  synchronous, active-high reset.
REQ-005 SHALL have these Wishbone slave ports:
  wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  cycle, strobe, write enable.
  wbs_sel_i  in  4  byte lane enables.
  wbs_adr_i, wbs_dat_i  in  32 each  address, write data.
  wbs_ack_o  out  1  acknowledge.
  wbs_dat_o  out  32  read data.
REQ-006 SHALL have these logic-analyser and IO ports:
  la_data_in, la_oenb  in  128 each  logic-analyser inputs and output-enables (active low).
  la_data_out  out  128  logic-analyser outputs.
  io_out, io_oeb  out  NUM_CH each  per-channel toggle outputs and output enables.
  irq  out  3  interrupt lines.

Function
REQ-007 SHALL decode a hit when wbs_adr_i[31:8]==BASE_ADR[31:8]; channel index = adr[7:4]; register = adr[3:2]: 0 CTRL, 1 LOAD, 2 COUNT, 3 STATUS.
REQ-008 CTRL bits SHALL be: [0] en, [1] down, [2] oneshot, [3] irq_en; other bits read 0.
REQ-009 STATUS SHALL be: [0] done (sticky, write-1-to-clear), [1] running (read-only, equals en).
REQ-010 SHALL assert wbs_ack_o for exactly one cycle, in the cycle after cyc&stb&hit&!wbs_ack_o; back-to-back accesses therefore ack every other cycle.
REQ-011 Non-hit addresses SHALL never be acked.
REQ-012 A hit to a channel index >= NUM_CH SHALL be acked, read 0, and ignore writes.
REQ-013 Writes SHALL honour wbs_sel_i per byte; register bits above CNT_W SHALL be ignored on write and read 0.
REQ-014 wbs_dat_o SHALL be registered, valid while wbs_ack_o is high, and 0 otherwise.
REQ-015 Up mode (en=1, down=0): COUNT SHALL increment by 1 per cycle; on the cycle COUNT==LOAD, the next COUNT SHALL be 0, done SHALL be set, and io_out[ch] SHALL toggle.
REQ-016 Down mode (en=1, down=1): COUNT SHALL decrement by 1 per cycle; on the cycle COUNT==0, the next COUNT SHALL be LOAD, done SHALL be set, and io_out[ch] SHALL toggle.
REQ-017 If oneshot=1, a terminal event SHALL additionally clear en and hold COUNT at its wrapped/reloaded value.
REQ-018 Pause: when la_oenb[ch]==0 and la_data_in[ch]==1, the channel SHALL hold COUNT unchanged; terminal detection SHALL be suppressed while paused.
REQ-019 A Wishbone write to COUNT SHALL take priority over the increment/decrement in the same cycle.
REQ-020 A write setting en SHALL begin counting on the following cycle.
REQ-021 A hardware done-set SHALL take priority over a same-cycle W1C clear.
REQ-022 irq[0] SHALL be the registered OR over channels of (done & irq_en); irq[2:1] SHALL be 0.
REQ-023 la_data_out[NUM_CH-1:0] SHALL equal the done flags, la_data_out[64+:CNT_W] SHALL equal channel 0 COUNT, and all other la_data_out bits SHALL be 0.
REQ-024 io_oeb SHALL be all 0 (outputs driven).

Reset
REQ-025 While wb_rst_i=1 at a clock edge, all CTRL, LOAD, COUNT, done, io_out, wbs_ack_o, wbs_dat_o and irq SHALL become 0.
REQ-026 Reset asserted mid-transaction SHALL drop any pending ack; no ack SHALL be issued for that transaction.

Structure
REQ-027 A shared package user_proj_mc_pkg SHALL hold register offsets, CTRL/STATUS bit positions and the channel-register struct typedef.
REQ-028 Per-channel counting SHALL reside in one sub-module, user_proj_mc_channel, instantiated NUM_CH times via generate.
REQ-029 Bus decode and read mux SHALL reside in the top level.

Verification
REQ-030 Up wrap: ch0 LOAD=3, CTRL=0x1 -> COUNT sequence 1,2,3,0,1; done=1; io_out[0] toggles once per 4 cycles.
REQ-031 Down oneshot: ch1 LOAD=2, COUNT=2, CTRL=0x7 -> COUNT 1,0,2 then holds; en reads 0; STATUS reads 0x1.
REQ-032 IRQ/W1C: ch2 irq_en=1, done set -> irq[0]=1; write STATUS=0x1 -> irq[0]=0 one cycle later unless a terminal event coincides.
REQ-033 Bus: read of channel 5 (NUM_CH=4) -> ack, data 0; non-hit address -> no ack within 8 cycles; sel=4'b0001 write of LOAD=0xFFFF_FFFF -> LOAD=0x0000_00FF.
REQ-034 Priority/pause: COUNT write of 0x10 while counting -> next read 0x10 plus elapsed cycles; la_oenb[0]=0 with la_data_in[0]=1 -> COUNT frozen.
